// File: rtl/seq_pkg.sv
// Shared state encoding and halt-reason codes for the instruction sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

endpackage

// File: rtl/inst_sequencer_wait_timer.sv
// Handshake watchdog: counts cycles spent waiting and flags when WAIT_MAX is reached.
// Saturates at WAIT_MAX so it never wraps back to a non-expired value.
module wait_timer #(
    parameter int WAIT_MAX = 1023
) (
    input  logic clk,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [W-1:0] cnt_q;

    assign expired_o = (cnt_q == W'(WAIT_MAX));

    always_ff @(posedge clk) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/mem/writeback sequencer: owns pc, latched instruction and
// retire count; halts on ebreak, illegal instruction or a bus handshake timeout.
module inst_sequencer
    import seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          WAIT_MAX = 1023
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        mem_valid_i,
    input  logic        is_ebreak_i,
    input  logic        illegal_i,
    input  logic [31:0] next_pc,
    output logic        lsu_req,
    input  logic        lsu_done,
    output logic        rf_wen_gate,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halt,
    output logic [1:0]  halt_code
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic [1:0]  halt_code_q;

    logic waiting;
    logic expired;

    // Counter only runs while a bus handshake is outstanding; any other state re-arms it.
    assign waiting = (state_q == FETCH) || (state_q == MEM);

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .clear_i   (rst || !waiting),
        .enable_i  (waiting),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            instret_q   <= '0;
            halt_code_q <= HALT_NONE;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ifu_rvalid) begin
                        inst_q  <= ifu_rdata;
                        state_q <= DECODE;
                    end else if (expired) begin
                        halt_code_q <= HALT_TIMEOUT;
                        state_q     <= HALT;
                    end
                end
                DECODE: begin
                    if (illegal_i) begin
                        halt_code_q <= HALT_ILLEGAL;
                        state_q     <= HALT;
                    end else if (is_ebreak_i) begin
                        halt_code_q <= HALT_EBREAK;
                        state_q     <= HALT;
                    end else if (mem_valid_i) begin
                        state_q <= MEM;
                    end else begin
                        state_q <= WB;
                    end
                end
                MEM: begin
                    if (lsu_done) begin
                        state_q <= WB;
                    end else if (expired) begin
                        halt_code_q <= HALT_TIMEOUT;
                        state_q     <= HALT;
                    end
                end
                WB: begin
                    pc_q      <= next_pc;
                    instret_q <= instret_q + 32'd1;
                    state_q   <= FETCH;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign ifu_req     = (state_q == FETCH);
    assign ifu_addr    = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = (state_q == DECODE) || (state_q == MEM) || (state_q == WB);
    assign lsu_req     = (state_q == MEM);
    assign rf_wen_gate = (state_q == WB);
    assign retire      = (state_q == WB);
    assign pc          = pc_q;
    assign instret     = instret_q;
    assign halt        = (state_q == HALT);
    assign halt_code   = halt_code_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: default instance for the main flow, WAIT_MAX=4 instance for timeouts.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_t = 1'b1;
    logic        ifu_rvalid = 1'b0;
    logic [31:0] ifu_rdata = '0;
    logic        mem_valid_i = 1'b0;
    logic        is_ebreak_i = 1'b0;
    logic        illegal_i = 1'b0;
    logic [31:0] next_pc = '0;
    logic        lsu_done = 1'b0;

    logic        ifu_req, inst_valid, lsu_req, rf_wen_gate, retire, halt;
    logic [31:0] ifu_addr, inst, pc, instret;
    logic [1:0]  halt_code;

    logic        t_ifu_req, t_inst_valid, t_lsu_req, t_rf_wen_gate, t_retire, t_halt;
    logic [31:0] t_ifu_addr, t_inst, t_pc, t_instret;
    logic [1:0]  t_halt_code;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_sequencer dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .mem_valid_i(mem_valid_i), .is_ebreak_i(is_ebreak_i), .illegal_i(illegal_i),
        .next_pc(next_pc), .lsu_req(lsu_req), .lsu_done(lsu_done),
        .rf_wen_gate(rf_wen_gate), .pc(pc), .retire(retire), .instret(instret),
        .halt(halt), .halt_code(halt_code)
    );

    inst_sequencer #(.WAIT_MAX(4)) dut_t (
        .clk(clk), .rst(rst_t),
        .ifu_req(t_ifu_req), .ifu_addr(t_ifu_addr), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .inst(t_inst), .inst_valid(t_inst_valid),
        .mem_valid_i(mem_valid_i), .is_ebreak_i(is_ebreak_i), .illegal_i(illegal_i),
        .next_pc(next_pc), .lsu_req(t_lsu_req), .lsu_done(lsu_done),
        .rf_wen_gate(t_rf_wen_gate), .pc(t_pc), .retire(t_retire), .instret(t_instret),
        .halt(t_halt), .halt_code(t_halt_code)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        mem_valid_i = 1'b0;
        is_ebreak_i = 1'b0;
        illegal_i   = 1'b0;
        next_pc     = '0;
        lsu_done    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ifu_req !== 1'b1) begin n_err++; $display("FAIL reset_ifu_req got %b want 1", ifu_req); end
        n_cmp++; if (ifu_addr !== 32'h8000_0000) begin n_err++; $display("FAIL reset_ifu_addr got %h want 80000000", ifu_addr); end
        n_cmp++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_pc got %h want 80000000", pc); end
        n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", inst); end
        n_cmp++; if (instret !== 32'h0) begin n_err++; $display("FAIL reset_instret got %h want 0", instret); end
        n_cmp++; if ({halt, halt_code} !== 3'b000) begin n_err++; $display("FAIL reset_halt got %b%b want 000", halt, halt_code); end
        n_cmp++; if ({inst_valid, lsu_req, rf_wen_gate, retire} !== 4'b0000) begin
            n_err++; $display("FAIL reset_strobes got %b%b%b%b want 0000", inst_valid, lsu_req, rf_wen_gate, retire); end
    endtask

    task automatic test_alu();
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0050_0093;
        step();
        ifu_rvalid = 1'b0;
        ifu_rdata  = 32'hFFFF_FFFF;
        next_pc    = 32'h8000_0004;
        n_cmp++; if (inst !== 32'h0050_0093) begin n_err++; $display("FAIL alu_inst got %h want 00500093", inst); end
        n_cmp++; if ({ifu_req, inst_valid, rf_wen_gate} !== 3'b010) begin
            n_err++; $display("FAIL alu_decode got %b%b%b want 010", ifu_req, inst_valid, rf_wen_gate); end
        step();
        n_cmp++; if ({rf_wen_gate, retire, inst_valid} !== 3'b111) begin
            n_err++; $display("FAIL alu_wb got %b%b%b want 111", rf_wen_gate, retire, inst_valid); end
        n_cmp++; if (pc !== 32'h8000_0000) begin n_err++; $display("FAIL alu_pc_wb got %h want 80000000", pc); end
        step();
        n_cmp++; if (pc !== 32'h8000_0004) begin n_err++; $display("FAIL alu_pc got %h want 80000004", pc); end
        n_cmp++; if (instret !== 32'd1) begin n_err++; $display("FAIL alu_instret got %0d want 1", instret); end
        n_cmp++; if ({ifu_req, retire} !== 2'b10) begin n_err++; $display("FAIL alu_refetch got %b%b want 10", ifu_req, retire); end
    endtask

    task automatic test_load();
        int req_cycles = 0;
        int bad = 0;
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0000_A103;
        step();
        ifu_rvalid  = 1'b0;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (lsu_req === 1'b1) req_cycles++;
            if (rf_wen_gate !== 1'b0 || inst !== 32'h0000_A103 || inst_valid !== 1'b1) bad++;
            lsu_done = (i == 6);
            step();
        end
        lsu_done = 1'b0;
        next_pc  = 32'h8000_0008;
        n_cmp++; if (req_cycles != 6) begin n_err++; $display("FAIL load_req_cycles got %0d want 6", req_cycles); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL load_mem_stable got %0d bad cycles want 0", bad); end
        n_cmp++; if ({lsu_req, rf_wen_gate, retire} !== 3'b011) begin
            n_err++; $display("FAIL load_wb got %b%b%b want 011", lsu_req, rf_wen_gate, retire); end
        step();
        n_cmp++; if (pc !== 32'h8000_0008) begin n_err++; $display("FAIL load_pc got %h want 80000008", pc); end
        n_cmp++; if (instret !== 32'd2) begin n_err++; $display("FAIL load_instret got %0d want 2", instret); end
    endtask

    task automatic test_ebreak();
        int strobes = 0;
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0010_0073;
        step();
        ifu_rvalid  = 1'b0;
        is_ebreak_i = 1'b1;
        step();
        is_ebreak_i = 1'b0;
        n_cmp++; if ({halt, halt_code} !== 3'b101) begin n_err++; $display("FAIL ebreak_halt got %b%b want 101", halt, halt_code); end
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0050_0093;
        next_pc    = 32'hDEAD_BEEC;
        lsu_done   = 1'b1;
        mem_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ifu_req || inst_valid || lsu_req || rf_wen_gate || retire) strobes++;
        end
        clear_inputs();
        n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL ebreak_strobes got %0d active cycles want 0", strobes); end
        n_cmp++; if (pc !== 32'h8000_0008) begin n_err++; $display("FAIL ebreak_pc got %h want 80000008", pc); end
        n_cmp++; if (instret !== 32'd2) begin n_err++; $display("FAIL ebreak_instret got %0d want 2", instret); end
        n_cmp++; if (inst !== 32'h0010_0073) begin n_err++; $display("FAIL ebreak_inst got %h want 00100073", inst); end
        n_cmp++; if ({halt, halt_code} !== 3'b101) begin n_err++; $display("FAIL ebreak_sticky got %b%b want 101", halt, halt_code); end
    endtask

    task automatic test_illegal();
        do_reset();
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'hFFFF_FFFF;
        step();
        ifu_rvalid  = 1'b0;
        illegal_i   = 1'b1;
        is_ebreak_i = 1'b1;
        mem_valid_i = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if ({halt, halt_code} !== 3'b110) begin n_err++; $display("FAIL illegal_code got %b%b want 110", halt, halt_code); end
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL illegal_instret got %0d want 0", instret); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0000_A103;
        step();
        ifu_rvalid  = 1'b0;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0;
        step();
        n_cmp++; if (lsu_req !== 1'b1) begin n_err++; $display("FAIL rstmem_in_mem got %b want 1", lsu_req); end
        rst = 1'b1;
        lsu_done = 1'b1;
        step();
        rst = 1'b0;
        lsu_done = 1'b0;
        n_cmp++; if ({ifu_req, lsu_req, inst_valid} !== 3'b100) begin
            n_err++; $display("FAIL rstmem_strobes got %b%b%b want 100", ifu_req, lsu_req, inst_valid); end
        n_cmp++; if (pc !== 32'h8000_0000 || instret !== 32'd0 || inst !== 32'd0) begin
            n_err++; $display("FAIL rstmem_regs got pc=%h instret=%h inst=%h want 80000000/0/0", pc, instret, inst); end
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        n_cmp++; if (instret !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload got %h want ffffffff", instret); end
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0;
        step();
        ifu_rvalid = 1'b0;
        next_pc    = 32'h8000_0004;
        step();
        n_cmp++; if (retire !== 1'b1) begin n_err++; $display("FAIL bubble_retire got %b want 1", retire); end
        step();
        n_cmp++; if (instret !== 32'd0) begin n_err++; $display("FAIL wrap_instret got %h want 0", instret); end
        n_cmp++; if (pc !== 32'h8000_0004) begin n_err++; $display("FAIL bubble_pc got %h want 80000004", pc); end
    endtask

    task automatic test_timeout();
        int early = 0;
        clear_inputs();
        rst   = 1'b1;
        rst_t = 1'b1;
        step();
        rst_t = 1'b0;
        ifu_rvalid = 1'b1;
        ifu_rdata  = 32'h0000_A103;
        step();
        ifu_rvalid  = 1'b0;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (t_halt !== 1'b0 || t_lsu_req !== 1'b1) early++;
            step();
        end
        n_cmp++; if (early != 0) begin n_err++; $display("FAIL timeout_mem_wait got %0d bad cycles want 0", early); end
        n_cmp++; if ({t_halt, t_halt_code, t_lsu_req} !== 4'b1110) begin
            n_err++; $display("FAIL timeout_mem got %b%b%b want 1110", t_halt, t_halt_code, t_lsu_req); end

        rst_t = 1'b1;
        step();
        rst_t = 1'b0;
        ifu_rvalid = 1'b1;
        step();
        ifu_rvalid  = 1'b0;
        mem_valid_i = 1'b1;
        step();
        mem_valid_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            lsu_done = (i == 5);
            step();
        end
        lsu_done = 1'b0;
        next_pc  = 32'h8000_0004;
        n_cmp++; if ({t_halt, t_halt_code, t_retire, t_rf_wen_gate} !== 5'b00011) begin
            n_err++; $display("FAIL timeout_edge_done got %b%b%b%b want 00011", t_halt, t_halt_code, t_retire, t_rf_wen_gate); end
        step();
        n_cmp++; if (t_pc !== 32'h8000_0004 || t_ifu_addr !== 32'h8000_0004 || t_instret !== 32'd1) begin
            n_err++; $display("FAIL timeout_edge_retire got pc=%h addr=%h instret=%h want 80000004/80000004/1", t_pc, t_ifu_addr, t_instret); end
        n_cmp++; if (t_inst !== 32'h0000_A103 || t_inst_valid !== 1'b0 || t_ifu_req !== 1'b1) begin
            n_err++; $display("FAIL timeout_edge_fetch got inst=%h iv=%b req=%b want 0000a103/0/1", t_inst, t_inst_valid, t_ifu_req); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if ({t_halt, t_halt_code, t_ifu_req} !== 4'b1110) begin
            n_err++; $display("FAIL timeout_fetch got %b%b%b want 1110", t_halt, t_halt_code, t_ifu_req); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_ebreak();
        test_illegal();
        test_reset_mid_mem();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
